// File: rtl/dvp_cam_emulator.sv
// DVP (OV5640-style) camera source: pclk = clk/2, vsync/href framing and an
// RGB565 byte stream carrying either a coordinate pattern or eight colour bars.
module dvp_cam_emulator #(
    parameter int H_ACT    = 1280,
    parameter int V_ACT    = 720,
    parameter int H_BLANK  = 64,
    parameter int VS_WIDTH = 8,
    parameter int VS_BACK  = 32,
    parameter int V_TAIL   = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        cam_rstn,
    input  logic        pat_sel,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int BAR_W = H_ACT / 8;
    localparam int M_V   = (VS_WIDTH > VS_BACK) ? VS_WIDTH : VS_BACK;
    localparam int M_H   = (H_BLANK > V_TAIL) ? H_BLANK : V_TAIL;
    localparam int C_MAX = (M_V > M_H) ? M_V : M_H;
    localparam int CW    = $clog2(C_MAX + 1);
    localparam int XW    = $clog2(H_ACT + 1);
    localparam int YW    = $clog2(V_ACT + 1);
    localparam int BW    = $clog2(BAR_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_LINE,
        S_HBLANK,
        S_VTAIL
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XW-1:0]   x_cnt;
    logic [YW-1:0]   y_cnt;
    logic [BW-1:0]   bar_px;
    logic [2:0]      bar_idx;
    logic            lo_byte;
    logic            pat_q;

    logic            step;
    logic            line_last;
    logic            bar_wrap;
    logic [2:0]      bar_next;
    logic [15:0]     pix_cur;
    logic [15:0]     pix_nxt;
    logic [15:0]     pix_first;

    function automatic logic [15:0] pixel(input logic pat, input logic [YW-1:0] y,
                                          input logic [XW-1:0] x, input logic [2:0] b);
        logic [15:0] p;
        p = 16'h0000;
        if (!pat) begin
            p = {8'(y), 8'(x)};
        end else begin
            case (b)
                3'd0:    p = 16'hFFFF;
                3'd1:    p = 16'hFFE0;
                3'd2:    p = 16'h07FF;
                3'd3:    p = 16'h07E0;
                3'd4:    p = 16'hF81F;
                3'd5:    p = 16'hF800;
                3'd6:    p = 16'h001F;
                default: p = 16'h0000;
            endcase
        end
        return p;
    endfunction

    // Everything except pclk advances only on the clk edge where pclk falls.
    assign step      = cam_pclk;
    assign line_last = (x_cnt == XW'(H_ACT - 1));
    assign bar_wrap  = (bar_px == BW'(BAR_W - 1));
    assign bar_next  = bar_wrap ? bar_idx + 3'd1 : bar_idx;
    assign pix_cur   = pixel(pat_q, y_cnt, x_cnt, bar_idx);
    assign pix_nxt   = pixel(pat_q, y_cnt, x_cnt + XW'(1), bar_next);
    assign pix_first = pixel(pat_q, y_cnt, '0, 3'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cam_pclk   <= 1'b0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
            state      <= S_IDLE;
            cnt        <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            bar_px     <= '0;
            bar_idx    <= 3'd0;
            lo_byte    <= 1'b0;
            pat_q      <= 1'b0;
        end else begin
            cam_pclk   <= ~cam_pclk;
            frame_done <= 1'b0;
            if (step) begin
                if (!cam_rstn) begin
                    state     <= S_IDLE;
                    cam_vsync <= 1'b0;
                    cam_href  <= 1'b0;
                    cam_data  <= 8'h00;
                    cnt       <= '0;
                    lo_byte   <= 1'b0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (enable) begin
                                state     <= S_VSYNC;
                                cam_vsync <= 1'b1;
                                pat_q     <= pat_sel;
                                y_cnt     <= '0;
                                cnt       <= '0;
                            end
                        end
                        S_VSYNC: begin
                            if (cnt == CW'(VS_WIDTH - 1)) begin
                                state     <= S_VBACK;
                                cam_vsync <= 1'b0;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        S_VBACK, S_HBLANK: begin
                            if ((state == S_VBACK  && cnt == CW'(VS_BACK - 1)) ||
                                (state == S_HBLANK && cnt == CW'(H_BLANK - 1))) begin
                                state    <= S_LINE;
                                cam_href <= 1'b1;
                                cam_data <= pix_first[15:8];
                                x_cnt    <= '0;
                                bar_px   <= '0;
                                bar_idx  <= 3'd0;
                                lo_byte  <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        S_LINE: begin
                            if (!lo_byte) begin
                                lo_byte  <= 1'b1;
                                cam_data <= pix_cur[7:0];
                            end else if (line_last) begin
                                cam_href <= 1'b0;
                                cam_data <= 8'h00;
                                lo_byte  <= 1'b0;
                                cnt      <= '0;
                                if (y_cnt == YW'(V_ACT - 1)) begin
                                    state <= S_VTAIL;
                                end else begin
                                    state <= S_HBLANK;
                                    y_cnt <= y_cnt + YW'(1);
                                end
                            end else begin
                                lo_byte  <= 1'b0;
                                x_cnt    <= x_cnt + XW'(1);
                                bar_px   <= bar_wrap ? '0 : bar_px + BW'(1);
                                bar_idx  <= bar_next;
                                cam_data <= pix_nxt[15:8];
                            end
                        end
                        S_VTAIL: begin
                            if (cnt == CW'(V_TAIL - 1)) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                                cnt        <= '0;
                                if (enable) begin
                                    state     <= S_VSYNC;
                                    cam_vsync <= 1'b1;
                                    pat_q     <= pat_sel;
                                    y_cnt     <= '0;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: begin
                            state     <= S_IDLE;
                            cam_vsync <= 1'b0;
                            cam_href  <= 1'b0;
                            cam_data  <= 8'h00;
                        end
                    endcase
                end
            end
        end
    end

endmodule
